// File: rtl/vdp18_pkg.sv
// Shared VDP18 types and the per-mode VRAM slot allocation table.
// The access scheduler and any VRAM client decode access_t from here.
package vdp18_pkg;

  typedef enum logic [1:0] {
    TEXTM  = 2'd0,
    GRAPH1 = 2'd1,
    GRAPH2 = 2'd2,
    MULTIC = 2'd3
  } opmode_t;

  typedef enum logic [2:0] {
    AC_NONE = 3'd0,
    AC_PNT  = 3'd1,
    AC_PCT  = 3'd2,
    AC_PGT  = 3'd3,
    AC_CPU  = 3'd4
  } access_t;

  localparam int SLOTS_GRAPH  = 4;
  localparam int SLOTS_TEXT   = 3;
  localparam int PIX_PER_SLOT = 2;

  // Last pixel phase of a pattern before pix_q wraps to 0.
  localparam logic [2:0] PIX_LAST_GRAPH = 3'(SLOTS_GRAPH * PIX_PER_SLOT - 1);
  localparam logic [2:0] PIX_LAST_TEXT  = 3'(SLOTS_TEXT * PIX_PER_SLOT - 1);

  // Slot owner inside the active display area. AC_CPU marks a slot the CPU
  // may use; whether it actually does depends on a pending request.
  function automatic access_t slot_access(input opmode_t mode, input logic [1:0] slot);
    access_t acc;
    acc = AC_NONE;
    case (mode)
      TEXTM: begin
        case (slot)
          2'd0:    acc = AC_PNT;
          2'd1:    acc = AC_PGT;
          2'd2:    acc = AC_CPU;
          default: acc = AC_NONE;
        endcase
      end
      MULTIC: begin
        case (slot)
          2'd0:    acc = AC_PNT;
          2'd1:    acc = AC_NONE;
          2'd2:    acc = AC_PGT;
          default: acc = AC_CPU;
        endcase
      end
      default: begin
        case (slot)
          2'd0:    acc = AC_PNT;
          2'd1:    acc = AC_PCT;
          2'd2:    acc = AC_PGT;
          default: acc = AC_CPU;
        endcase
      end
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/vdp18_access_sched.sv
// VRAM access slot scheduler: divides each pattern into 2-pixel slots and
// grants them to the display fetch pipeline or to a pending CPU request.
module vdp18_access_sched
  import vdp18_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_en_5m37_i,
  input  opmode_t    opmode_i,
  input  logic       line_start_i,
  input  logic       active_i,
  input  logic       cpu_req_i,
  output access_t    access_type_o,
  output logic       clk_en_acc_o,
  output logic       cpu_ack_o,
  output logic [1:0] slot_o
);

  logic [2:0] pix_q, pix_d;
  logic       pending_q, pending_d;
  logic       armed_q, armed_d;
  access_t    access_type_q, access_type_d;
  logic [1:0] slot_q, slot_d;

  logic       pix_wrap;
  logic       slot_start;
  access_t    slot_kind;

  // The access completes on the last pixel of its slot; the ack rides along.
  assign clk_en_acc_o  = clk_en_5m37_i & pix_q[0];
  assign cpu_ack_o     = clk_en_acc_o & (access_type_q == AC_CPU);
  assign access_type_o = access_type_q;
  assign slot_o        = slot_q;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pix_wrap = (opmode_i == TEXTM) ? (pix_q >= PIX_LAST_TEXT)
                                   : (pix_q == PIX_LAST_GRAPH);
    pix_d = pix_q;
    if (line_start_i) begin
      pix_d = '0;
    end else if (clk_en_5m37_i) begin
      pix_d = pix_wrap ? 3'd0 : pix_q + 3'd1;
    end

    // A request is latched only once per assertion: armed re-opens when the
    // CPU releases cpu_req_i after being acknowledged.
    pending_d = pending_q;
    armed_d   = armed_q;
    if (cpu_ack_o) begin
      pending_d = 1'b0;
      armed_d   = 1'b0;
    end else begin
      if (cpu_req_i && armed_q) pending_d = 1'b1;
      if (!cpu_req_i)           armed_d   = 1'b1;
    end

    slot_start = (line_start_i | clk_en_5m37_i) & ~pix_d[0];
    slot_kind  = active_i ? slot_access(opmode_i, pix_d[2:1]) : AC_CPU;

    // Use the post-ack pending state so back-to-back CPU slots cannot
    // grant the same request twice.
    access_type_d = access_type_q;
    slot_d        = slot_q;
    if (slot_start) begin
      slot_d        = pix_d[2:1];
      access_type_d = (slot_kind == AC_CPU && !pending_d) ? AC_NONE : slot_kind;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pix_q         <= '0;
      pending_q     <= 1'b0;
      armed_q       <= 1'b1;
      access_type_q <= AC_NONE;
      slot_q        <= '0;
    end else begin
      pix_q         <= pix_d;
      pending_q     <= pending_d;
      armed_q       <= armed_d;
      access_type_q <= access_type_d;
      slot_q        <= slot_d;
    end
  end

endmodule

// File: tb/tb_vdp18_access_sched.sv
// Directed bench for the VRAM access slot scheduler.
module tb_vdp18_access_sched;
  import vdp18_pkg::*;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       clk_en     = 1'b0;
  logic       line_start = 1'b0;
  logic       active     = 1'b0;
  logic       cpu_req    = 1'b0;
  opmode_t    opmode     = GRAPH2;
  access_t    access_type;
  logic       acc_stb;
  logic       ack;
  logic [1:0] slot;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vdp18_access_sched dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .clk_en_5m37_i (clk_en),
    .opmode_i      (opmode),
    .line_start_i  (line_start),
    .active_i      (active),
    .cpu_req_i     (cpu_req),
    .access_type_o (access_type),
    .clk_en_acc_o  (acc_stb),
    .cpu_ack_o     (ack),
    .slot_o        (slot)
  );

  typedef struct {
    bit      en;
    bit      ls;
    opmode_t mode;
    bit      act;
    bit      req;
    int      exp_pix;
    access_t exp_type;
    int      exp_slot;
    int      exp_acc;
    int      exp_ack;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic sample_all(input string tag, input int pix, input access_t typ,
                            input int sl, input int acc, input int ak);
    check({tag, " pix"},  int'(dut.pix_q), pix);
    check({tag, " type"}, int'(access_type), int'(typ));
    check({tag, " slot"}, int'(slot), sl);
    check({tag, " acc"},  int'(acc_stb), acc);
    check({tag, " ack"},  int'(ack), ak);
  endtask

  // Drive the strobes for one cycle and stop at the falling edge to sample.
  task automatic set_and_sample(input bit en, input bit ls);
    clk_en     = en;
    line_start = ls;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    clk_en     = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic en_pulse();
    set_and_sample(1'b1, 1'b0);
    advance();
    idle();
  endtask

  task automatic line_restart();
    set_and_sample(1'b0, 1'b1);
    advance();
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    access_t g2_seq[8];
    int      n_ack;

    // GRAPH2 active, no CPU: PNT,PCT,PGT then an unused CPU slot.
    g2_seq = '{AC_PNT, AC_PNT, AC_PCT, AC_PCT, AC_PGT, AC_PGT, AC_NONE, AC_NONE};
    vecs.push_back('{1'b0, 1'b1, GRAPH2, 1'b1, 1'b0, 0, AC_NONE, 0, 0, 0});
    for (int k = 0; k < 16; k++)
      vecs.push_back('{1'b1, 1'b0, GRAPH2, 1'b1, 1'b0, k % 8, g2_seq[k % 8],
                       (k % 8) / 2, k % 2, 0});
    // TEXTM with the request held high: one ack on the 3rd strobe only.
    vecs.push_back('{1'b0, 1'b1, TEXTM, 1'b1, 1'b1, 0, AC_PNT, 0, 0, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 0, AC_PNT, 0, 0, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 1, AC_PNT, 0, 1, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 2, AC_PGT, 1, 0, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 3, AC_PGT, 1, 1, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 4, AC_CPU, 2, 0, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 5, AC_CPU, 2, 1, 1});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 0, AC_PNT, 0, 0, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 1, AC_PNT, 0, 1, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 2, AC_PGT, 1, 0, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 3, AC_PGT, 1, 1, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 4, AC_NONE, 2, 0, 0});
    vecs.push_back('{1'b1, 1'b0, TEXTM, 1'b1, 1'b1, 5, AC_NONE, 2, 1, 0});

    // Reset state, with the pixel enable toggling to show no strobe escapes.
    repeat (2) @(posedge clk);
    #1;
    clk_en = 1'b1;
    @(negedge clk);
    sample_all("reset", 0, AC_NONE, 0, 0, 0);
    check("reset pending", int'(dut.pending_q), 0);
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    rst_n  = 1'b1;

    foreach (vecs[i]) begin
      opmode  = vecs[i].mode;
      active  = vecs[i].act;
      cpu_req = vecs[i].req;
      set_and_sample(vecs[i].en, vecs[i].ls);
      sample_all($sformatf("vec%0d", i), vecs[i].exp_pix, vecs[i].exp_type,
                 vecs[i].exp_slot, vecs[i].exp_acc, vecs[i].exp_ack);
      advance();
      idle();
    end

    // Blanking: request raised at pix 1 is granted in the slot starting at pix 2.
    opmode  = GRAPH1;
    active  = 1'b0;
    cpu_req = 1'b0;
    line_restart();
    en_pulse();
    cpu_req = 1'b1;
    idle();
    set_and_sample(1'b1, 1'b0);
    sample_all("blank p1", 1, AC_NONE, 0, 1, 0);
    advance();
    idle();
    set_and_sample(1'b1, 1'b0);
    sample_all("blank p2", 2, AC_CPU, 1, 0, 0);
    advance();
    idle();
    set_and_sample(1'b1, 1'b0);
    sample_all("blank p3", 3, AC_CPU, 1, 1, 1);
    advance();
    idle();
    set_and_sample(1'b1, 1'b0);
    sample_all("blank p4", 4, AC_NONE, 2, 0, 0);
    advance();
    idle();
    cpu_req = 1'b0;
    idle();

    // Line start coinciding with a pixel enable at pix 5.
    active = 1'b1;
    line_restart();
    repeat (5) en_pulse();
    set_and_sample(1'b1, 1'b1);
    sample_all("ls p5", 5, AC_PGT, 2, 1, 0);
    advance();
    @(negedge clk);
    sample_all("ls after", 0, AC_PNT, 0, 0, 0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a granted CPU slot.
    active  = 1'b0;
    cpu_req = 1'b1;
    idle();
    line_restart();
    set_and_sample(1'b1, 1'b0);
    sample_all("rst pre", 0, AC_CPU, 0, 0, 0);
    advance();
    #2;
    rst_n   = 1'b0;
    clk_en  = 1'b1;
    cpu_req = 1'b0;
    #1;
    sample_all("rst async", 0, AC_NONE, 0, 0, 0);
    check("rst pending", int'(dut.pending_q), 0);
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    idle();
    rst_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 8; k++) begin
      set_and_sample(1'b1, 1'b0);
      if (ack) n_ack++;
      advance();
      idle();
    end
    check("rst no ack", n_ack, 0);

    // MULTIC -> TEXTM switch at pix 6 wraps at the next enable.
    opmode = MULTIC;
    active = 1'b1;
    line_restart();
    for (int p = 0; p < 6; p++) begin
      set_and_sample(1'b1, 1'b0);
      if (p == 2) begin
        check("multic slot1 type", int'(access_type), int'(AC_NONE));
        check("multic slot1 idx", int'(slot), 1);
      end
      advance();
      idle();
    end
    opmode = TEXTM;
    set_and_sample(1'b1, 1'b0);
    sample_all("mode p6", 6, AC_NONE, 3, 0, 0);
    advance();
    @(negedge clk);
    sample_all("mode wrap", 0, AC_PNT, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
